// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG front-end scheduler.
package psg_pkg;

    localparam int PSG_ATTR_ADDR_W = 6;
    localparam int PSG_ATTR_DATA_W = 8;
    localparam int PSG_NUM_CH      = 16;
    // 6 clocks per channel plus one closing clock.
    localparam int PSG_CALC_CYCLES = PSG_NUM_CH * 6 + 1;

    typedef struct packed {
        logic [PSG_ATTR_ADDR_W-1:0] addr;
        logic [PSG_ATTR_DATA_W-1:0] data;
    } psg_attr_wr_t;

    typedef enum logic {
        RR_HOST = 1'b0,
        RR_SEQ  = 1'b1
    } psg_rr_t;

endpackage

// File: rtl/psg_ctrl_fifo.sv
// Attribute write FIFO: DEPTH entries (power of two), registered level.
module psg_ctrl_fifo
    import psg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  psg_attr_wr_t             wr_entry,
    input  logic                     pop,
    output psg_attr_wr_t             rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    psg_attr_wr_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/psg_ctrl.sv
// PSG front-end: sample tick, calculation-window tracking, host/sequencer
// write arbitration and FIFO drain. Macro PSG_CTRL_FRAME_LOCK_EN holds drains off during the window.
module psg_ctrl
    import psg_pkg::*;
#(
    parameter int SAMPLE_DIV  = 512,
    parameter int BUSY_CYCLES = PSG_CALC_CYCLES,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PSG_ATTR_ADDR_W-1:0]    host_addr,
    input  logic [PSG_ATTR_DATA_W-1:0]    host_data,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [PSG_ATTR_ADDR_W-1:0]    seq_addr,
    input  logic [PSG_ATTR_DATA_W-1:0]    seq_data,
    input  logic                          seq_valid,
    output logic                          seq_ready,
    output logic [PSG_ATTR_ADDR_W-1:0]    attr_addr,
    output logic [PSG_ATTR_DATA_W-1:0]    attr_wrdata,
    output logic                          attr_write,
    output logic                          next_sample,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int BW = $clog2(BUSY_CYCLES + 1);

    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] busy_cnt;
    logic          tick_wrap;
    logic          drain_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    psg_attr_wr_t  push_entry;
    psg_attr_wr_t  head;
    psg_rr_t       rr_q;
    psg_rr_t       rr_d;

    // ---- sample tick and calculation window ----
    assign tick_wrap = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));
    assign busy      = (busy_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            next_sample <= 1'b0;
            busy_cnt    <= '0;
        end else begin
            tick_cnt    <= (!enable || tick_wrap) ? '0 : tick_cnt + 1'b1;
            next_sample <= tick_wrap;
            if (tick_wrap)
                busy_cnt <= BW'(BUSY_CYCLES);
            else if (busy)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // ---- arbiter: round-robin only matters when both requesters are valid ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_q <= RR_HOST;
        else
            rr_q <= rr_d;
    end

    always_comb begin
        host_ready = 1'b0;
        seq_ready  = 1'b0;
        rr_d       = rr_q;
        if (!fifo_full) begin
            if (host_valid && (!seq_valid || rr_q == RR_HOST))
                host_ready = 1'b1;
            else if (seq_valid)
                seq_ready = 1'b1;
            if (host_valid && seq_valid)
                rr_d = (rr_q == RR_HOST) ? RR_SEQ : RR_HOST;
        end
    end

    assign push            = host_ready || seq_ready;
    assign push_entry.addr = host_ready ? host_addr : seq_addr;
    assign push_entry.data = host_ready ? host_data : seq_data;

    // ---- drain ----
`ifdef PSG_CTRL_FRAME_LOCK_EN
    // Also block the edge that opens a window: the PSG starts reading right after it.
    assign drain_ok = !busy && !tick_wrap;
`else
    assign drain_ok = 1'b1;
`endif

    assign pop = !fifo_empty && drain_ok;

    psg_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_entry (push_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            attr_write  <= 1'b0;
            attr_addr   <= '0;
            attr_wrdata <= '0;
        end else begin
            attr_write <= pop;
            if (pop) begin
                attr_addr   <= head.addr;
                attr_wrdata <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_psg_ctrl.sv
// Directed bench for psg_ctrl: tick/window timing, arbitration, FIFO drain, reset.
module tb_psg_ctrl;
    import psg_pkg::*;

    localparam int LW = 3;
`ifdef PSG_CTRL_FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [5:0]    host_addr = '0;
    logic [7:0]    host_data = '0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [5:0]    seq_addr = '0;
    logic [7:0]    seq_data = '0;
    logic          seq_valid = 1'b0;
    logic          seq_ready;
    logic [5:0]    attr_addr;
    logic [7:0]    attr_wrdata;
    logic          attr_write;
    logic          next_sample;
    logic          busy;
    logic [LW-1:0] fifo_level;

    psg_ctrl #(.SAMPLE_DIV(512), .BUSY_CYCLES(97), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .host_addr(host_addr), .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .seq_addr(seq_addr), .seq_data(seq_data), .seq_valid(seq_valid), .seq_ready(seq_ready),
        .attr_addr(attr_addr), .attr_wrdata(attr_wrdata), .attr_write(attr_write),
        .next_sample(next_sample), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int busy1 = 0;
    int lock_viol = 0;
    int wr_k[$];
    logic [13:0] wr_v[$];
    int ns_k[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
        if (attr_write) begin
            wr_k.push_back(k);
            wr_v.push_back({attr_addr, attr_wrdata});
        end
        if (next_sample) ns_k.push_back(k);
        if (busy && k >= 512 && k < 1024) busy1++;
        if (attr_write && busy) lock_viol++;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_attr_write"}, 32'(attr_write), 0);
        chk({tag, "_next_sample"}, 32'(next_sample), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_level"}, 32'(fifo_level), 0);
        chk({tag, "_attr_addr"}, 32'(attr_addr), 0);
        chk({tag, "_attr_data"}, 32'(attr_wrdata), 0);
    endtask

    initial begin
        int base;
        int nf;
        int acc_k[5];
        logic [13:0] exp_c[4];

        // ---- reset state ----
        step(); step();
        chk_zero_outputs("reset");
        chk("reset_host_ready", 32'(host_ready), 0);
        chk("reset_seq_ready", 32'(seq_ready), 0);
        rst_n = 1'b1;
        step();

        // ---- single host write, idle ----
        host_addr = 6'h05; host_data = 8'hA3; host_valid = 1'b1;
        #1;
        chk("single_host_ready", 32'(host_ready), 1);
        chk("single_seq_ready", 32'(seq_ready), 0);
        step();
        host_valid = 1'b0;
        chk("single_level1", 32'(fifo_level), 1);
        chk("single_no_early_write", 32'(attr_write), 0);
        step();
        chk("single_write", 32'(attr_write), 1);
        chk("single_addr", 32'(attr_addr), 32'h05);
        chk("single_data", 32'(attr_wrdata), 32'hA3);
        chk("single_level0", 32'(fifo_level), 0);
        step();
        chk("single_pulse", 32'(attr_write), 0);
        chk("single_addr_hold", 32'(attr_addr), 32'h05);

        // ---- contention: grants alternate host, seq, host, seq ----
        base = wr_v.size();
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_addr = 6'(i);        host_data = 8'(32'h20 + i);
            seq_valid  = 1'b1; seq_addr  = 6'(32'h10 + i); seq_data  = 8'(32'h30 + i);
            #1;
            chk($sformatf("cont_host_ready%0d", i), 32'(host_ready), 32'((i % 2) == 0));
            chk($sformatf("cont_seq_ready%0d", i), 32'(seq_ready), 32'((i % 2) == 1));
            step();
        end
        host_valid = 1'b0; seq_valid = 1'b0;
        step(); step(); step();
        exp_c[0] = {6'h00, 8'h20};
        exp_c[1] = {6'h11, 8'h31};
        exp_c[2] = {6'h02, 8'h22};
        exp_c[3] = {6'h13, 8'h33};
        chk("cont_count", 32'(wr_v.size() - base), 4);
        for (int i = 0; i < 4; i++)
            if (base + i < wr_v.size())
                chk($sformatf("cont_order%0d", i), 32'(wr_v[base + i]), 32'(exp_c[i]));

        // ---- tick timeline: k counts edges since enable rose ----
        wr_k.delete(); wr_v.delete(); ns_k.delete();
        k = 0; busy1 = 0; lock_viol = 0; nf = 0;
        foreach (acc_k[i]) acc_k[i] = 0;
        enable = 1'b1;
        while (k < 1540) begin
            step();
            host_valid = 1'b0;
            if (k == 608) chk("busy_last", 32'(busy), 1);
            if (k == 609) chk("busy_fell", 32'(busy), 0);
            if (k == 512) begin
                host_valid = 1'b1; host_addr = 6'h10; host_data = 8'h11;
                #1 chk("lock_host_ready", 32'(host_ready), 1);
            end
            if (k == 1040) chk("full_level", 32'(fifo_level), LOCK ? 4 : 0);
            if (k >= 1030 && nf < 5) begin
                host_valid = 1'b1; host_addr = 6'(32'h20 + nf); host_data = 8'(32'h40 + nf);
                #1;
                if (host_ready) begin acc_k[nf] = k; nf++; end
            end
            if (k >= 1536 && k <= 1538) begin
                host_valid = 1'b1; host_addr = 6'(32'h30 + k - 1536); host_data = 8'(32'h50 + k - 1536);
            end
        end
        chk("ns_count", 32'(ns_k.size()), 3);
        if (ns_k.size() == 3) begin
            chk("ns_first", 32'(ns_k[0]), 512);
            chk("ns_second", 32'(ns_k[1]), 1024);
            chk("ns_third", 32'(ns_k[2]), 1536);
        end
        chk("busy_len", 32'(busy1), 97);
        for (int i = 0; i < 4; i++)
            chk($sformatf("full_accept%0d", i), 32'(acc_k[i]), 32'(1030 + i));
        chk("full_accept4", 32'(acc_k[4]), LOCK ? 1122 : 1034);
        chk("wr_count", 32'(wr_v.size()), LOCK ? 6 : 9);
        if (wr_v.size() >= 6) begin
            chk("lock_entry", 32'(wr_v[0]), 32'({6'h10, 8'h11}));
            chk("lock_time", 32'(wr_k[0]), LOCK ? 610 : 514);
            for (int i = 0; i < 5; i++)
                chk($sformatf("full_order%0d", i), 32'(wr_v[1 + i]), 32'({6'(32'h20 + i), 8'(32'h40 + i)}));
            chk("full_first_time", 32'(wr_k[1]), LOCK ? 1122 : 1032);
        end
`ifdef PSG_CTRL_FRAME_LOCK_EN
        chk("lock_no_write_busy", 32'(lock_viol), 0);
`endif

        // ---- reset mid-window ----
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_level", 32'(fifo_level), LOCK ? 3 : 0);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        step(); step();
        rst_n = 1'b1;
        base = wr_v.size();
        k = 0;
        ns_k.delete();
        // Tick restarts from zero, then enable drops before the first wrap.
        for (int i = 0; i < 300; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 600; i++) step();
        chk("post_reset_no_write", 32'(wr_v.size() - base), 0);
        chk("disable_no_pulse", 32'(ns_k.size()), 0);
        chk("post_reset_level", 32'(fifo_level), 0);
        chk("post_reset_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
